// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-attached command RAM: opcodes, frame layout, TX FSM states.
package spi_ram_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef struct packed {
        cmd_e              op;
        logic [DATA_W-1:0] payload;
    } frame_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// MEM_DEPTH x 8 single-port array with registered read; out-of-range writes are
// dropped and out-of-range reads return zero.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              w_ok;
    logic              r_ok;

    assign w_ok = (32'(waddr) < MEM_DEPTH);
    assign r_ok = (32'(raddr) < MEM_DEPTH);

    // Array itself is never reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we && w_ok)
            mem[waddr[IW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= r_ok ? mem[raddr[IW-1:0]] : '0;
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder behind the SPI slave: one command per rising edge of rx_valid,
// address registers, and a hold counter that keeps tx_valid up for TX_HOLD cycles.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TX_HOLD   = 8,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid
);

    localparam int unsigned CW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    frame_t               frame;
    logic                 rx_valid_d;
    logic                 accept;
    logic                 wr_go;
    logic                 rd_go;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    state_e               state;
    state_e               state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;

    assign frame  = frame_t'(din);
    // Reset has priority, so nothing is accepted on a reset edge.
    assign accept = rst_n & rx_valid & ~rx_valid_d;
    assign wr_go  = accept & (frame.op == CMD_WR_DATA);
    assign rd_go  = accept & (frame.op == CMD_RD_DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_d <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
        end else begin
            rx_valid_d <= rx_valid;
            if (accept) begin
                case (frame.op)
                    CMD_WR_ADDR: wr_addr <= ADDR_SIZE'(frame.payload);
                    CMD_WR_DATA: begin
                        if (AUTO_INC != 0)
                            wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
                    end
                    CMD_RD_ADDR: rd_addr <= ADDR_SIZE'(frame.payload);
                    default:     ;
                endcase
            end
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_go),
        .waddr (wr_addr),
        .wdata (frame.payload),
        .re    (rd_go),
        .raddr (rd_addr),
        .rdata (dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A new RD_DATA always restarts the hold window, even mid-TX.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: ;
            ST_TX: begin
                if (cnt == '0)
                    state_nxt = ST_IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rd_go) begin
            state_nxt = ST_TX;
            cnt_nxt   = CW'(TX_HOLD - 1);
        end
    end

    assign tx_valid = (state == ST_TX);

endmodule
